// File: rtl/cons_allocator.sv
// Cons-cell allocator: bump-allocates two-word cells and fetches them over the post-boot RAM port.
// Optional CONS_HEAP_CLEAR_EN zeroes the heap once after boot before requests are accepted.
module cons_allocator #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] HEAP_BASE  = 16'h0100,
  parameter logic [ADDR_WIDTH-1:0] HEAP_END   = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  boot_done,
  input  logic                  memory_error,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [DATA_WIDTH-1:0] req_car,
  input  logic [DATA_WIDTH-1:0] req_cdr,
  input  logic [ADDR_WIDTH-1:0] req_ptr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADDR_WIDTH-1:0] rsp_ptr,
  output logic [DATA_WIDTH-1:0] rsp_car,
  output logic [DATA_WIDTH-1:0] rsp_cdr,
  output logic                  rsp_fault,
  output logic [ADDR_WIDTH-1:0] free_ptr,
  output logic                  error
);

  // Highest address at which a two-word cell still fits.
  localparam logic [ADDR_WIDTH-1:0] LAST_CELL = HEAP_END - 1'b1;

  typedef enum logic [3:0] {
    S_WAIT_BOOT,
    S_IDLE,
    S_ALLOC_CAR,
    S_ALLOC_CDR,
    S_FETCH_CAR,
    S_FETCH_CDR,
    S_FETCH_LAST,
    S_RESP,
    S_ERROR
`ifdef CONS_HEAP_CLEAR_EN
    , S_HEAP_CLEAR
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] free_q, free_d;
  logic [DATA_WIDTH-1:0] car_q, car_d, cdr_q, cdr_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] rsp_ptr_q, rsp_ptr_d;
  logic [DATA_WIDTH-1:0] rsp_car_q, rsp_car_d, rsp_cdr_q, rsp_cdr_d;
  logic                  rsp_fault_q, rsp_fault_d;
`ifdef CONS_HEAP_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clr_q, clr_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_WAIT_BOOT;
      free_q      <= HEAP_BASE;
      car_q       <= '0;
      cdr_q       <= '0;
      ptr_q       <= '0;
      rsp_ptr_q   <= '0;
      rsp_car_q   <= '0;
      rsp_cdr_q   <= '0;
      rsp_fault_q <= 1'b0;
`ifdef CONS_HEAP_CLEAR_EN
      clr_q       <= HEAP_BASE;
`endif
    end else begin
      state_q     <= state_d;
      free_q      <= free_d;
      car_q       <= car_d;
      cdr_q       <= cdr_d;
      ptr_q       <= ptr_d;
      rsp_ptr_q   <= rsp_ptr_d;
      rsp_car_q   <= rsp_car_d;
      rsp_cdr_q   <= rsp_cdr_d;
      rsp_fault_q <= rsp_fault_d;
`ifdef CONS_HEAP_CLEAR_EN
      clr_q       <= clr_d;
`endif
    end
  end

  always_comb begin
    state_d          = state_q;
    free_d           = free_q;
    car_d            = car_q;
    cdr_d            = cdr_q;
    ptr_d            = ptr_q;
    rsp_ptr_d        = rsp_ptr_q;
    rsp_car_d        = rsp_car_q;
    rsp_cdr_d        = rsp_cdr_q;
    rsp_fault_d      = rsp_fault_q;
`ifdef CONS_HEAP_CLEAR_EN
    clr_d            = clr_q;
`endif
    mem_write_enable = 1'b0;
    mem_addr         = '0;
    mem_write_data   = '0;
    req_ready        = 1'b0;
    rsp_valid        = 1'b0;

    case (state_q)
      S_WAIT_BOOT: begin
        if (boot_done) begin
`ifdef CONS_HEAP_CLEAR_EN
          state_d = S_HEAP_CLEAR;
          clr_d   = HEAP_BASE;
`else
          state_d = S_IDLE;
`endif
        end
      end
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          car_d       = req_car;
          cdr_d       = req_cdr;
          ptr_d       = req_ptr;
          rsp_ptr_d   = '0;
          rsp_car_d   = '0;
          rsp_cdr_d   = '0;
          rsp_fault_d = 1'b0;
          if (!req_op) begin
            if (free_q > LAST_CELL) begin
              rsp_fault_d = 1'b1;
              state_d     = S_RESP;
            end else begin
              state_d = S_ALLOC_CAR;
            end
          end else if (req_ptr < HEAP_BASE || req_ptr > LAST_CELL) begin
            rsp_fault_d = 1'b1;
            rsp_ptr_d   = req_ptr;
            state_d     = S_RESP;
          end else begin
            state_d = S_FETCH_CAR;
          end
        end
      end
      S_ALLOC_CAR: begin
        mem_write_enable = 1'b1;
        mem_addr         = free_q;
        mem_write_data   = car_q;
        state_d          = S_ALLOC_CDR;
      end
      S_ALLOC_CDR: begin
        mem_write_enable = 1'b1;
        mem_addr         = free_q + 1'b1;
        mem_write_data   = cdr_q;
        rsp_ptr_d        = free_q;
        free_d           = free_q + ADDR_WIDTH'(2);
        state_d          = S_RESP;
      end
      S_FETCH_CAR: begin
        mem_addr = ptr_q;
        state_d  = S_FETCH_CDR;
      end
      // Read data lags the address by one cycle, so each word lands a state later.
      S_FETCH_CDR: begin
        mem_addr  = ptr_q + 1'b1;
        rsp_car_d = mem_read_data;
        state_d   = S_FETCH_LAST;
      end
      S_FETCH_LAST: begin
        rsp_cdr_d = mem_read_data;
        rsp_ptr_d = ptr_q;
        state_d   = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      S_ERROR: ;
`ifdef CONS_HEAP_CLEAR_EN
      S_HEAP_CLEAR: begin
        mem_write_enable = 1'b1;
        mem_addr         = clr_q;
        if (clr_q == HEAP_END) state_d = S_IDLE;
        else                   clr_d   = clr_q + 1'b1;
      end
`endif
      default: state_d = S_ERROR;
    endcase

    if (memory_error) state_d = S_ERROR;
    // An abandoned access must not strobe the RAM while reset is asserted.
    if (rst) mem_write_enable = 1'b0;
  end

  assign rsp_ptr   = rsp_ptr_q;
  assign rsp_car   = rsp_car_q;
  assign rsp_cdr   = rsp_cdr_q;
  assign rsp_fault = rsp_fault_q;
  assign free_ptr  = free_q;
  assign error     = (state_q == S_ERROR);

endmodule

// File: tb/tb_cons_allocator.sv
// Scoreboard bench for cons_allocator: reference model predicts responses and RAM writes.
module tb_cons_allocator;
  localparam logic [15:0] BASE = 16'h0100;
  localparam logic [15:0] HEND = 16'h0103;

  logic        clk, rst, boot_done, memory_error;
  logic        mem_write_enable;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data, mem_read_data;
  logic        req_valid, req_ready, req_op;
  logic [31:0] req_car, req_cdr;
  logic [15:0] req_ptr;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_ptr;
  logic [31:0] rsp_car, rsp_cdr;
  logic        rsp_fault;
  logic [15:0] free_ptr;
  logic        error;

  cons_allocator #(.HEAP_BASE(BASE), .HEAP_END(HEND)) dut (
    .clk(clk), .rst(rst), .boot_done(boot_done), .memory_error(memory_error),
    .mem_write_enable(mem_write_enable), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_car(req_car), .req_cdr(req_cdr), .req_ptr(req_ptr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ptr(rsp_ptr),
    .rsp_car(rsp_car), .rsp_cdr(rsp_cdr), .rsp_fault(rsp_fault),
    .free_ptr(free_ptr), .error(error)
  );

  typedef struct { logic [15:0] ptr; logic [31:0] car; logic [31:0] cdr; logic fault; } rsp_t;
  typedef struct { logic [15:0] a; logic [31:0] d; } wr_t;

  rsp_t        rq[$];
  wr_t         wq[$];
  logic [31:0] ram  [0:65535];
  logic [31:0] mmem [0:65535];
  logic [15:0] mfree;
  int          n_chk = 0, n_fail = 0;
  bit          rr_mode = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // RAM behaviour of the memory controller: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_write_enable) ram[mem_addr] <= mem_write_data;
    mem_read_data <= ram[mem_addr];
  end

  always begin
    @(posedge clk); #1;
    if (rr_mode) rsp_ready = 1'($urandom_range(0, 1));
  end

  rsp_t me;
  wr_t  mw;
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (rq.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        me = rq.pop_front();
        chk("rsp_fault", rsp_fault, me.fault);
        if (!me.fault) chk("rsp_ptr", rsp_ptr, me.ptr);
        chk("rsp_car", rsp_car, me.car);
        chk("rsp_cdr", rsp_cdr, me.cdr);
      end
    end
    if (mem_write_enable) begin
      if (wq.size() == 0) chk("write_unexpected", {mem_addr, mem_write_data}, 0);
      else begin
        mw = wq.pop_front();
        chk("write_addr", mem_addr, mw.a);
        chk("write_data", mem_write_data, mw.d);
      end
    end
  end

  task automatic expect_clear();
`ifdef CONS_HEAP_CLEAR_EN
    for (int a = BASE; a <= HEND; a++) begin
      wq.push_back('{16'(a), 32'h0});
      mmem[a] = 32'h0;
    end
`endif
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mfree = BASE;
    @(negedge clk);
    chk("rst_free_ptr", free_ptr, BASE);
    chk("rst_error", error, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_fields", {rsp_ptr, rsp_car, rsp_cdr, rsp_fault}, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mem_idle", {mem_write_enable, mem_addr, mem_write_data}, 0);
    if (boot_done) expect_clear();
  endtask

  // Issue one request, update the model at acceptance and check response latency.
  task automatic issue(input bit op, input logic [31:0] car, input logic [31:0] cdr,
                       input logic [15:0] ptr);
    rsp_t e;
    int   n, lat;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_car = car; req_cdr = cdr; req_ptr = ptr;
    n = 0;
    while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!req_ready) chk("req_ready_timeout", 0, 1);
    if (!op) begin
      e.fault = (int'(mfree) > int'(HEND) - 1);
      e.ptr = mfree; e.car = 0; e.cdr = 0;
      if (!e.fault) begin
        wq.push_back('{mfree, car});
        wq.push_back('{mfree + 16'd1, cdr});
        mmem[mfree] = car; mmem[mfree + 16'd1] = cdr;
        mfree = mfree + 16'd2;
      end
      lat = e.fault ? 1 : 3;
    end else begin
      e.fault = (ptr < BASE) || (int'(ptr) > int'(HEND) - 1);
      e.ptr = ptr;
      e.car = e.fault ? 32'h0 : mmem[ptr];
      e.cdr = e.fault ? 32'h0 : mmem[ptr + 16'd1];
      lat = e.fault ? 1 : 4;
    end
    rq.push_back(e);
    @(posedge clk); #1 req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
    chk(op ? "fetch_latency" : "alloc_latency", n, lat);
  endtask

  task automatic wait_done();
    int n = 0;
    while (rq.size() != 0 && n < 200) begin @(posedge clk); n++; end
    if (rq.size() != 0) begin
      chk("rsp_timeout", rq.size(), 0);
      rq.delete();
    end
    @(negedge clk);
    chk("free_ptr", free_ptr, mfree);
    chk("idle_req_ready", req_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 65536; a++) begin ram[a] = 32'h0; mmem[a] = 32'h0; end
    rst = 1'b1; boot_done = 1'b0; memory_error = 1'b0;
    req_valid = 1'b0; req_op = 1'b0; req_car = '0; req_cdr = '0; req_ptr = '0;
    rsp_ready = 1'b1;
    do_reset();

    // Boot wait: requests are refused and nothing is written.
    req_valid = 1'b1; req_car = 32'hAAAA_5555;
    repeat (20) begin
      @(negedge clk);
      chk("boot_req_ready", req_ready, 0);
      chk("boot_no_write", mem_write_enable, 0);
    end
    @(posedge clk); #1 req_valid = 1'b0; boot_done = 1'b1;
    expect_clear();
    @(posedge clk);
    @(negedge clk);
`ifdef CONS_HEAP_CLEAR_EN
    for (int n = 0; n < 100 && !req_ready; n++) @(negedge clk);
    chk("clear_all_written", wq.size(), 0);
`endif
    chk("boot_req_ready_up", req_ready, 1);

    // Directed allocation / fetch / exhaustion.
    issue(1'b0, 32'hDEAD_0001, 32'h0, 16'h0);
    wait_done();
    rsp_ready = 1'b0;
    issue(1'b1, 32'h0, 32'h0, 16'h0100);
    repeat (5) begin
      @(negedge clk);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_fields", {rsp_ptr, rsp_car, rsp_cdr, rsp_fault}, {16'h0100, 32'hDEAD_0001, 32'h0, 1'b0});
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_done();
    issue(1'b0, 32'h1111_2222, 32'h3333_4444, 16'h0);
    wait_done();
    issue(1'b0, 32'h5555_6666, 32'h7777_8888, 16'h0);
    wait_done();
    chk("exhausted_free_ptr", free_ptr, 16'h0104);
    issue(1'b1, 32'h0, 32'h0, 16'h00FF);
    wait_done();
    issue(1'b1, 32'h0, 32'h0, 16'h0103);
    wait_done();
    issue(1'b1, 32'h0, 32'h0, 16'h0102);
    wait_done();

    // Memory fault during the car write: the cdr write must never appear.
    do_reset();
    for (int n = 0; n < 100 && !req_ready; n++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 1'b0; req_car = 32'hCAFE_0001; req_cdr = 32'hCAFE_0002;
    @(posedge clk); #1 req_valid = 1'b0; memory_error = 1'b1;
    wq.push_back('{mfree, 32'hCAFE_0001});
    mmem[mfree] = 32'hCAFE_0001;
    @(posedge clk); #1 memory_error = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("err_sticky", error, 1);
      chk("err_rsp_valid", rsp_valid, 0);
      chk("err_req_ready", req_ready, 0);
    end
    chk("err_writes_drained", wq.size(), 0);
    do_reset();

    // Randomised epochs, each starting from a fresh reset.
    rr_mode = 1;
    for (int ep = 0; ep < 6; ep++) begin
      for (int i = 0; i < 10; i++) begin
        if ($urandom_range(0, 1) == 0)
          issue(1'b0, $urandom, $urandom, 16'h0);
        else
          issue(1'b1, 32'h0, 32'h0, 16'($urandom_range(16'h00FE, 16'h0104)));
        wait_done();
      end
      do_reset();
    end
    rr_mode = 0;
    rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    chk("end_rsp_queue", rq.size(), 0);
    chk("end_write_queue", wq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cons_allocator.md
Name: cons_allocator

Overview:
Initiator-side client of the memory controller's post-boot RAM port. It waits for boot completion, then serves two kinds of cons-cell requests over a valid/ready handshake:
- ALLOC: bump-allocates a two-word cell (car at p, cdr at p+1) and writes both words.
- FETCH: reads both words of the cell at a given pointer.
It sits between the evaluator datapath and the memory controller, and absorbs the RAM's one-cycle read latency.

Parameters:
ADDR_WIDTH, 16, RAM address width; must match the memory controller.
DATA_WIDTH, 32, RAM word width; must match the memory controller.
HEAP_BASE, 16'h0100, first heap address; reset value of free_ptr; must be even.
HEAP_END, 16'hFFFF, last usable heap address (inclusive).

Ports:
clk  in  1  clock
rst  in  1  reset
boot_done  in  1  memory controller finished ROM->RAM boot
memory_error  in  1  memory controller fault
mem_write_enable  out  1  RAM write strobe to controller
mem_addr  out  ADDR_WIDTH  RAM address to controller
mem_write_data  out  DATA_WIDTH  RAM write data to controller
mem_read_data  in  DATA_WIDTH  RAM read data; valid the cycle after mem_addr is presented
req_valid  in  1  request present
req_ready  out  1  allocator can accept a request
req_op  in  1  0=ALLOC, 1=FETCH
req_car  in  DATA_WIDTH  car word (ALLOC)
req_cdr  in  DATA_WIDTH  cdr word (ALLOC)
req_ptr  in  ADDR_WIDTH  cell pointer (FETCH)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_ptr  out  ADDR_WIDTH  allocated pointer (ALLOC) / echoed req_ptr (FETCH)
rsp_car  out  DATA_WIDTH  fetched car (FETCH); 0 for ALLOC
rsp_cdr  out  DATA_WIDTH  fetched cdr (FETCH); 0 for ALLOC
rsp_fault  out  1  request refused (out of heap / pointer out of range)
free_ptr  out  ADDR_WIDTH  next free cell address
error  out  1  sticky memory fault

Behaviour:
- Reset: rst, synchronous, active-high; clock clk.
  - Reset state: WAIT_BOOT; free_ptr=HEAP_BASE; rsp_valid=0; rsp_ptr/rsp_car/rsp_cdr=0; rsp_fault=0; error=0.
  - Reset mid-operation abandons the request; no further writes are issued.
- Memory-side outputs are decoded from the state and latched request registers only. There is no combinational path from req_* inputs to mem_*.
- When no access is in progress: mem_write_enable=0, mem_addr=0, mem_write_data=0.
- States and transitions:
  - WAIT_BOOT: req_ready=0. Go to IDLE when boot_done=1 (or HEAP_CLEAR, see optional feature).
  - IDLE: req_ready=1. On req_valid&&req_ready, latch req_op/car/cdr/ptr.
    - ALLOC: if free_ptr > HEAP_END-1, go to RESP with rsp_fault=1 and no writes; else go to ALLOC_CAR.
    - FETCH: if req_ptr < HEAP_BASE or req_ptr > HEAP_END-1, go to RESP with rsp_fault=1; else go to FETCH_CAR.
  - ALLOC_CAR: we=1, addr=free_ptr, data=car. Go to ALLOC_CDR.
  - ALLOC_CDR: we=1, addr=free_ptr+1, data=cdr. Register rsp_ptr=free_ptr, then free_ptr<=free_ptr+2. Go to RESP.
  - FETCH_CAR: addr=ptr. Go to FETCH_CDR.
  - FETCH_CDR: addr=ptr+1; capture mem_read_data into rsp_car. Go to FETCH_LAST.
  - FETCH_LAST: capture mem_read_data into rsp_cdr; rsp_ptr=ptr. Go to RESP.
  - RESP: rsp_valid=1; response fields held stable until rsp_valid&&rsp_ready, then go to IDLE. req_ready=0 while in RESP.
  - ERROR: error=1, req_ready=0, rsp_valid=0, no memory access. Exit only via rst.
- Latency, with the request accepted at cycle 0:
  - ALLOC writes in cycles 1-2; rsp_valid from cycle 3.
  - FETCH rsp_valid from cycle 4.
  - Faulted requests: rsp_valid from cycle 1.
- Back-to-back throughput: one request per RESP handshake. No pipelining.
- memory_error=1 in any state goes to ERROR next cycle and takes priority over every other transition; any in-flight response is dropped.
- Address arithmetic is modulo 2^ADDR_WIDTH. The range checks above guarantee p+1 never wraps for accepted requests.
- A faulted ALLOC leaves free_ptr unchanged. The heap is never freed (no GC in this block).

Optional Feature:
- Macro: CONS_HEAP_CLEAR_EN.
- Defined: WAIT_BOOT goes to HEAP_CLEAR on boot_done. HEAP_CLEAR writes 0 to every address HEAP_BASE..HEAP_END, one word per cycle (we=1), with req_ready=0, then goes to IDLE. memory_error during HEAP_CLEAR goes to ERROR.
- Undefined: no HEAP_CLEAR state; WAIT_BOOT goes directly to IDLE. Heap contents are whatever boot loaded.

Test Plan:
- Hold boot_done=0 for 20 cycles with req_valid=1 -> req_ready=0, no mem_write_enable. Raise boot_done -> req_ready=1 the next cycle.
- ALLOC car=32'hDEAD_0001, cdr=32'h0000_0000 after boot -> writes addr 0x0100=DEAD0001 and 0x0101=0 on cycles 1-2; rsp_ptr=0x0100, rsp_fault=0; free_ptr=0x0102. A second ALLOC -> rsp_ptr=0x0102.
- FETCH ptr=0x0100 after that ALLOC -> rsp_car=32'hDEAD_0001, rsp_cdr=0, rsp_valid at cycle 4. Hold rsp_ready=0 for 5 cycles -> fields stable, req_ready=0.
- Run with HEAP_END=16'h0103 -> 2 ALLOCs succeed; the third returns rsp_fault=1 with free_ptr=0x0104 and no writes. FETCH ptr=0x00FF or 0x0103 -> rsp_fault=1.
- Pulse memory_error during ALLOC_CAR -> ALLOC_CDR write never occurs; error=1 sticky; rsp_valid=0. rst -> error=0, free_ptr=0x0100.
- With CONS_HEAP_CLEAR_EN and HEAP_END=16'h010F -> exactly 16 zero writes to 0x0100..0x010F after boot_done, then req_ready=1.
